// File: rtl/rom_load_sink.sv
// rom_load_sink: packs a little-endian byte stream into 16-bit words, queues
// them in a small FIFO and writes them to memory over a req/ack port. It also
// captures the cartridge header fields as they stream past.
// Optional feature: define LOADER_CHECKSUM_EN to add a running byte-sum
// checksum and a comparison against the header checksum.
module rom_load_sink #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [23:0] HDR_BASE   = 24'h7FC0
) (
  input  logic        wclk,
  input  logic        resetn,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        loading,
  output logic        mem_req,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic        mem_ack,
  output logic [7:0]  map_ctrl,
  output logic [3:0]  rom_size,
  output logic [23:0] rom_mask,
  output logic [23:0] ram_mask,
  output logic [23:0] byte_count,
  output logic        done,
  output logic        overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum,
  output logic        checksum_ok
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [22:0] addr;
    logic [15:0] data;
  } entry_t;

  state_e        state_q, state_d;
  logic          loading_q;
  logic [23:0]   byte_count_q;
  logic [7:0]    pending_q;
  logic          pend_valid_q;
  logic          overflow_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    map_ctrl_q, rom_size_q, ram_size_q;
  entry_t        fifo_mem [FIFO_DEPTH];

  logic   accept, restart, fifo_full, fifo_empty;
  logic   data_push, flush_push, push_req, push_ok, pop;
  entry_t push_entry, head;

  assign accept     = (state_q == RECV) && loading && din_valid;
  assign restart    = (state_q == DONE) && loading && !loading_q;
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  // A completed word arrives with every odd-indexed byte.
  assign data_push  = accept && byte_count_q[0];
  // A dangling low byte is padded out once loading has dropped; it waits for
  // room rather than being dropped.
  assign flush_push = pend_valid_q && !fifo_full &&
                      ((state_q == DRAIN) || ((state_q == RECV) && !loading));
  assign push_req   = data_push || flush_push;
  assign push_ok    = push_req && !fifo_full;
  assign pop        = mem_ack && !fifo_empty;

  // Both push sources target the word holding the pending low byte.
  assign push_entry.addr = byte_count_q[23:1];
  assign push_entry.data = data_push ? {din, pending_q} : {8'h00, pending_q};
  assign head            = fifo_mem[rd_ptr_q];

  // Next-state logic for the load sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (loading) state_d = RECV;
      RECV:    if (!loading) state_d = DRAIN;
      DRAIN:   if (fifo_empty && !pend_valid_q) state_d = DONE;
      DONE:    if (restart) state_d = RECV;
      default: state_d = IDLE;
    endcase
  end

  // State, byte pairing, FIFO bookkeeping and header capture.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      loading_q    <= 1'b0;
      byte_count_q <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      map_ctrl_q   <= '0;
      rom_size_q   <= '0;
      ram_size_q   <= '0;
    end else begin
      state_q   <= state_d;
      loading_q <= loading;
      if (restart) begin
        byte_count_q <= '0;
        pend_valid_q <= 1'b0;
        overflow_q   <= 1'b0;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        count_q      <= '0;
      end else begin
        if (accept) begin
          byte_count_q <= byte_count_q + 24'd1;
          if (!byte_count_q[0]) begin
            pending_q    <= din;
            pend_valid_q <= 1'b1;
          end
          if (byte_count_q == HDR_BASE + 24'h15) map_ctrl_q <= din;
          if (byte_count_q == HDR_BASE + 24'h17) rom_size_q <= din;
          if (byte_count_q == HDR_BASE + 24'h18) ram_size_q <= din;
        end
        if (data_push || flush_push) pend_valid_q <= 1'b0;
        if (push_req && fifo_full) overflow_q <= 1'b1;
        if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push_ok && !pop)      count_q <= count_q + 1'b1;
        else if (!push_ok && pop) count_q <= count_q - 1'b1;
      end
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array has no reset; outputs are gated by the empty flag
  // so stale contents are never visible.
  always_ff @(posedge wclk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= push_entry;
  end

  assign mem_req    = !fifo_empty;
  assign mem_addr   = fifo_empty ? '0 : head.addr;
  assign mem_din    = fifo_empty ? '0 : head.data;
  assign byte_count = byte_count_q;
  assign done       = (state_q == DONE);
  assign overflow   = overflow_q;
  assign map_ctrl   = map_ctrl_q;
  assign rom_size   = rom_size_q[3:0];
  assign rom_mask   = (24'h400 << rom_size_q[3:0]) - 24'd1;
  assign ram_mask   = (ram_size_q == 8'd0) ? 24'd0 : (24'h400 << ram_size_q) - 24'd1;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum_q, hdr_ck_q;

  // Running byte sum and header checksum capture.
  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      checksum_q <= '0;
      hdr_ck_q   <= '0;
    end else if (restart) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + {8'h00, din};
      if (byte_count_q == HDR_BASE + 24'h1E) hdr_ck_q[7:0]  <= din;
      if (byte_count_q == HDR_BASE + 24'h1F) hdr_ck_q[15:8] <= din;
    end
  end

  assign checksum    = checksum_q;
  assign checksum_ok = (state_q == DONE) && (checksum_q == hdr_ck_q);
`endif

endmodule
